// File: rtl/hex_sequence_controller_if.sv
// Board-side bundle for the HEX sequencer: synchronised-later user controls in,
// registered select code and status out.
interface hex_sequence_controller_if;
  logic       start;
  logic       pause;
  logic       step;
  logic       loop_en;
  logic [3:0] code_out;
  logic       busy;
  logic       done;

  modport master (
    output start, pause, step, loop_en,
    input  code_out, busy, done
  );

  modport slave (
    input  start, pause, step, loop_en,
    output code_out, busy, done
  );
endinterface

// File: rtl/hex_sequence_controller.sv
// Timed sequencer stepping the 7-segment decoder select code 0000->1000->1100->1110,
// with start/restart, pause with manual single-step, and optional looping.
module hex_sequence_controller #(
  parameter int TICK_DIV   = 50_000_000,
  parameter int HOLD_TICKS = 2
) (
  input logic                       CLOCK_50,
  input logic                       reset_n,
  hex_sequence_controller_if.slave  bus
);

  localparam int CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HOLD_W = $clog2(HOLD_TICKS + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(TICK_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);

  typedef enum logic [2:0] {IDLE, S1, S2, S3, HOLD} state_t;

  logic [1:0] startSync_q, pauseSync_q, stepSync_q, loopSync_q;
  logic       startPrev_q, stepPrev_q;
  logic       startRise_q, stepRise_q;

  logic [CNT_W-1:0]  count_q, count_d;
  logic [HOLD_W-1:0] holdCnt_q;
  state_t            state_q;
  logic [3:0]        code_q;
  logic              busy_q;
  logic              done_q;

  logic pauseS, loopS, tick;

  assign pauseS = pauseSync_q[1];
  assign loopS  = loopSync_q[1];

  // Edge pulses are registered so a raw rise reaches the FSM one cycle after detection.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      startSync_q <= '0;
      pauseSync_q <= '0;
      stepSync_q  <= '0;
      loopSync_q  <= '0;
      startPrev_q <= 1'b0;
      stepPrev_q  <= 1'b0;
      startRise_q <= 1'b0;
      stepRise_q  <= 1'b0;
    end else begin
      startSync_q <= {startSync_q[0], bus.start};
      pauseSync_q <= {pauseSync_q[0], bus.pause};
      stepSync_q  <= {stepSync_q[0], bus.step};
      loopSync_q  <= {loopSync_q[0], bus.loop_en};
      startPrev_q <= startSync_q[1];
      stepPrev_q  <= stepSync_q[1];
      startRise_q <= startSync_q[1] & ~startPrev_q;
      stepRise_q  <= stepSync_q[1] & ~stepPrev_q;
    end
  end

  always_comb begin
    count_d = count_q;
    if (startRise_q) begin
      count_d = '0;
    end else if (busy_q && !pauseS) begin
      count_d = (count_q == CNT_MAX) ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // While paused the frozen prescaler hands tick generation over to single-step.
  assign tick = busy_q && (pauseS ? stepRise_q : (count_q == CNT_MAX));

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      code_q    <= 4'b0000;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      holdCnt_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (startRise_q) begin
        state_q   <= S1;
        code_q    <= 4'b1000;
        busy_q    <= 1'b1;
        holdCnt_q <= '0;
      end else if (tick) begin
        case (state_q)
          S1: begin
            state_q <= S2;
            code_q  <= 4'b1100;
          end
          S2: begin
            state_q <= S3;
            code_q  <= 4'b1110;
          end
          S3: begin
            state_q   <= HOLD;
            code_q    <= 4'b1110;
            holdCnt_q <= '0;
          end
          HOLD: begin
            if (holdCnt_q == HOLD_LAST) begin
              holdCnt_q <= '0;
              if (loopS) begin
                state_q <= S1;
                code_q  <= 4'b1000;
              end else begin
                state_q <= IDLE;
                code_q  <= 4'b0000;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end else begin
              holdCnt_q <= holdCnt_q + 1'b1;
            end
          end
          default: begin
            state_q <= IDLE;
            code_q  <= 4'b0000;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.code_out = code_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_hex_sequence_controller.sv
// Directed bench for hex_sequence_controller with TICK_DIV=4, HOLD_TICKS=2;
// expected codes and latencies are worked out by hand from the sequencer timing.
module tb_hex_sequence_controller;

  logic clock;
  logic resetN;
  int   checkCount;
  int   errorCount;

  hex_sequence_controller_if bus ();

  hex_sequence_controller #(
    .TICK_DIV   (4),
    .HOLD_TICKS (2)
  ) dut (
    .CLOCK_50 (clock),
    .reset_n  (resetN),
    .bus      (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic applyStimulus(input logic s, input logic p, input logic st, input logic l);
    bus.start   = s;
    bus.pause   = p;
    bus.step    = st;
    bus.loop_en = l;
  endtask

  task automatic waitClk(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] actual, input logic [3:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic expectOut(input string tag, input logic [3:0] code, input logic busy, input logic done);
    checkOutput({tag, ".code"}, bus.code_out, code);
    checkOutput({tag, ".busy"}, {3'b000, bus.busy}, {3'b000, busy});
    checkOutput({tag, ".done"}, {3'b000, bus.done}, {3'b000, done});
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    resetN     = 1'b0;
    applyStimulus(0, 0, 0, 0);
    #12;
    expectOut("reset", 4'b0000, 0, 0);
    #1 resetN = 1'b1;
    waitClk(2);

    $display("[TB] basic sequence");
    applyStimulus(1, 0, 0, 0);
    waitClk(3);  expectOut("t1.pre",   4'b0000, 0, 0);
    waitClk(1);  expectOut("t1.s1",    4'b1000, 1, 0);
    applyStimulus(0, 0, 0, 0);
    waitClk(3);  expectOut("t1.s1end", 4'b1000, 1, 0);
    waitClk(1);  expectOut("t1.s2",    4'b1100, 1, 0);
    waitClk(4);  expectOut("t1.s3",    4'b1110, 1, 0);
    waitClk(4);  expectOut("t1.hold",  4'b1110, 1, 0);
    waitClk(7);  expectOut("t1.hlast", 4'b1110, 1, 0);
    waitClk(1);  expectOut("t1.done",  4'b0000, 0, 1);
    waitClk(1);  expectOut("t1.after", 4'b0000, 0, 0);

    $display("[TB] looping");
    applyStimulus(0, 0, 0, 1);
    waitClk(3);
    applyStimulus(1, 0, 0, 1);
    waitClk(4);  expectOut("t2.s1",    4'b1000, 1, 0);
    applyStimulus(0, 0, 0, 1);
    waitClk(19); expectOut("t2.hlast", 4'b1110, 1, 0);
    waitClk(1);  expectOut("t2.loop1", 4'b1000, 1, 0);
    waitClk(20); expectOut("t2.loop2", 4'b1000, 1, 0);
    applyStimulus(0, 0, 0, 0);
    waitClk(20); expectOut("t2.end",   4'b0000, 0, 1);
    waitClk(2);

    $display("[TB] pause and step");
    applyStimulus(1, 0, 0, 0);
    waitClk(4);  expectOut("t3.s1",    4'b1000, 1, 0);
    applyStimulus(0, 0, 0, 0);
    waitClk(4);  expectOut("t3.s2",    4'b1100, 1, 0);
    applyStimulus(0, 1, 0, 0);
    waitClk(40); expectOut("t3.paused", 4'b1100, 1, 0);
    applyStimulus(0, 1, 1, 0);
    waitClk(3);  expectOut("t3.steppre", 4'b1100, 1, 0);
    waitClk(1);  expectOut("t3.step",  4'b1110, 1, 0);
    applyStimulus(0, 1, 0, 0);
    waitClk(4);  expectOut("t3.held",  4'b1110, 1, 0);
    applyStimulus(0, 0, 0, 0);
    waitClk(11); expectOut("t3.resume", 4'b1110, 1, 0);
    waitClk(1);  expectOut("t3.done",  4'b0000, 0, 1);
    waitClk(2);

    $display("[TB] restart in S3, coincident with tick");
    applyStimulus(1, 0, 0, 0);
    waitClk(4);  expectOut("t4.s1",    4'b1000, 1, 0);
    applyStimulus(0, 0, 0, 0);
    waitClk(8);  expectOut("t4.s3",    4'b1110, 1, 0);
    applyStimulus(1, 0, 0, 0);
    waitClk(4);  expectOut("t4.restart", 4'b1000, 1, 0);
    applyStimulus(0, 0, 0, 0);
    waitClk(3);  expectOut("t4.s1end", 4'b1000, 1, 0);
    waitClk(1);  expectOut("t4.s2",    4'b1100, 1, 0);
    waitClk(4);  expectOut("t4.s3b",   4'b1110, 1, 0);
    waitClk(4);  expectOut("t4.hold",  4'b1110, 1, 0);
    waitClk(8);  expectOut("t4.done",  4'b0000, 0, 1);
    waitClk(2);

    $display("[TB] async reset in HOLD");
    applyStimulus(1, 0, 0, 0);
    waitClk(4);  expectOut("t5.s1",    4'b1000, 1, 0);
    applyStimulus(0, 0, 0, 0);
    waitClk(12); expectOut("t5.hold",  4'b1110, 1, 0);
    waitClk(3);
    #3 resetN = 1'b0;
    #1 expectOut("t5.async", 4'b0000, 0, 0);
    #2 resetN = 1'b1;
    waitClk(30); expectOut("t5.idle",  4'b0000, 0, 0);
    applyStimulus(1, 0, 0, 0);
    waitClk(4);  expectOut("t5.s1again", 4'b1000, 1, 0);
    applyStimulus(0, 0, 0, 0);
    waitClk(20); expectOut("t5.done",  4'b0000, 0, 1);
    waitClk(2);

    $display("[TB] ignored steps and start glitches");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 1, 0);
      waitClk(2);
      applyStimulus(0, 0, 0, 0);
      waitClk(2);
    end
    waitClk(4);  expectOut("t6.idlestep", 4'b0000, 0, 0);
    applyStimulus(1, 0, 0, 0);
    waitClk(4);  expectOut("t6.s1",    4'b1000, 1, 0);
    applyStimulus(0, 0, 0, 0);
    waitClk(1);
    applyStimulus(0, 0, 1, 0);
    waitClk(3);  expectOut("t6.s2",    4'b1100, 1, 0);
    applyStimulus(0, 0, 0, 0);
    waitClk(2);  expectOut("t6.nostep", 4'b1100, 1, 0);
    waitClk(2);  expectOut("t6.s3",    4'b1110, 1, 0);
    waitClk(12); expectOut("t6.done",  4'b0000, 0, 1);
    waitClk(2);
    bus.start = 1'b1;
    #2 bus.start = 1'b0;
    waitClk(6);  expectOut("t6.glitch", 4'b0000, 0, 0);
    #7 bus.start = 1'b1;
    #3 bus.start = 1'b0;
    waitClk(3);  expectOut("t6.clean", 4'b1000, 1, 0);
    waitClk(3);  expectOut("t6.clean1", 4'b1000, 1, 0);
    waitClk(1);  expectOut("t6.clean2", 4'b1100, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
